// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/PC in, decoded immediate, format tag and target out.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_target;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_target
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_pc, out_target
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// One-cycle immediate generator (I/S/B/U/J/Z formats, RV32/RV64) with PC-relative target.
// Define IMMGEN_SKID_EN to add a skid register and a registered in_ready.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic signed [XLEN-1:0] imm;
        logic [2:0]             fmt;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        target;
    } ent_t;

    // Build the 32-bit immediate, then sign-extend to XLEN (zimm is non-negative, so it zero-extends).
    function automatic ent_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        ent_t               e;
        logic signed [31:0] v;
        fmt_e               f;
        v = '0;
        f = FMT_NONE;
        case (inst[6:0])
            OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_JALR: begin
                f = FMT_I;
                v = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    f = FMT_I;
                    v = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_STORE, OPC_STORE_FP: begin
                f = FMT_S;
                v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                f = FMT_B;
                v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                f = FMT_U;
                v = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                f = FMT_J;
                v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (inst[14]) begin
                    f = FMT_Z;
                    v = {27'b0, inst[19:15]};
                end
            end
            default: ;
        endcase
        e.fmt    = f;
        e.imm    = XLEN'(v);
        e.pc     = pc;
        e.target = pc + $unsigned(e.imm);
        return e;
    endfunction

    // p0: combinational decode of the incoming entry
    ent_t ent_p0;
    logic in_rdy;
    logic in_acc;

    assign ent_p0 = decode(bus.in_inst, bus.in_pc);
    assign in_acc = bus.in_valid && in_rdy;

    // p1: output register (plus optional skid register)
    ent_t main_p1_q, main_p1_d;
    logic vld_p1_q, vld_p1_d;

`ifdef IMMGEN_SKID_EN
    ent_t skid_p1_q, skid_p1_d;
    logic skid_vld_q, skid_vld_d;
    logic rdy_q;

    assign in_rdy = rdy_q && !reset;

    always_comb begin
        vld_p1_d   = vld_p1_q;
        main_p1_d  = main_p1_q;
        skid_vld_d = skid_vld_q;
        skid_p1_d  = skid_p1_q;
        if (flush) begin
            vld_p1_d   = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!vld_p1_q || bus.out_ready) begin
            // in_rdy is low whenever the skid holds an entry, so no input can arrive here then
            if (skid_vld_q) begin
                main_p1_d  = skid_p1_q;
                vld_p1_d   = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                vld_p1_d = in_acc;
                if (in_acc) main_p1_d = ent_p0;
            end
        end else if (in_acc) begin
            skid_p1_d  = ent_p0;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1_q   <= 1'b0;
            main_p1_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_p1_q  <= '0;
            rdy_q      <= 1'b1;
        end else begin
            vld_p1_q   <= vld_p1_d;
            main_p1_q  <= main_p1_d;
            skid_vld_q <= skid_vld_d;
            skid_p1_q  <= skid_p1_d;
            rdy_q      <= !skid_vld_d;
        end
    end
`else
    assign in_rdy = !reset && (!vld_p1_q || bus.out_ready);

    always_comb begin
        vld_p1_d  = vld_p1_q;
        main_p1_d = main_p1_q;
        if (flush) begin
            vld_p1_d = 1'b0;
        end else if (!vld_p1_q || bus.out_ready) begin
            vld_p1_d = in_acc;
            if (in_acc) main_p1_d = ent_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1_q  <= 1'b0;
            main_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            main_p1_q <= main_p1_d;
        end
    end
`endif

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = vld_p1_q;
    assign bus.out_imm    = main_p1_q.imm;
    assign bus.out_fmt    = main_p1_q.fmt;
    assign bus.out_pc     = main_p1_q.pc;
    assign bus.out_target = main_p1_q.target;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: runs an XLEN=32 and an XLEN=64 instance side by side.
module tb_imm_gen_pipe;
    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        drv_valid;
    logic [31:0] drv_inst;
    logic [63:0] drv_pc;
    logic        drv_ordy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();

    assign if32.in_valid  = drv_valid;
    assign if32.in_inst   = drv_inst;
    assign if32.in_pc     = drv_pc[31:0];
    assign if32.out_ready = drv_ordy;
    assign if64.in_valid  = drv_valid;
    assign if64.in_inst   = drv_inst;
    assign if64.in_pc     = drv_pc;
    assign if64.out_ready = drv_ordy;

    imm_gen_pipe #(.XLEN(32)) dut32 (.clock(clock), .reset(reset), .flush(flush), .bus(if32.slave));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clock(clock), .reset(reset), .flush(flush), .bus(if64.slave));

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [2:0]  fmt32;
        logic [31:0] imm32;
        logic [2:0]  fmt64;
        logic [63:0] imm64;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero_out(input string tag);
        chk({tag, " valid32"},  64'(if32.out_valid),  64'd0);
        chk({tag, " imm32"},    64'(if32.out_imm),    64'd0);
        chk({tag, " fmt32"},    64'(if32.out_fmt),    64'd0);
        chk({tag, " pc32"},     64'(if32.out_pc),     64'd0);
        chk({tag, " target32"}, 64'(if32.out_target), 64'd0);
        chk({tag, " valid64"},  64'(if64.out_valid),  64'd0);
        chk({tag, " imm64"},    if64.out_imm,         64'd0);
        chk({tag, " fmt64"},    64'(if64.out_fmt),    64'd0);
        chk({tag, " pc64"},     if64.out_pc,          64'd0);
        chk({tag, " target64"}, if64.out_target,      64'd0);
    endtask

    logic [31:0] got32[$];
    logic [63:0] got64[$];
    logic        rdy_c2, rdy_c3;
    logic        seen;
    logic [31:0] t32;
    int          idx;
    logic        acc;

    initial begin
        vecs[0]  = '{"addi0",  32'h00000013, 64'h100,  3'd1, 32'h0,        3'd1, 64'h0};
        vecs[1]  = '{"lui",    32'hFFFFF0B7, 64'h0,    3'd4, 32'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000};
        vecs[2]  = '{"beq-4",  32'hFE000EE3, 64'h200,  3'd3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC};
        vecs[3]  = '{"csrrwi", 32'h0001D073, 64'h300,  3'd6, 32'h3,        3'd6, 64'h3};
        vecs[4]  = '{"addiw",  32'hFFF0809B, 64'h400,  3'd0, 32'h0,        3'd1, 64'hFFFFFFFFFFFFFFFF};
        vecs[5]  = '{"sw-8",   32'hFE50AC23, 64'h1000, 3'd2, 32'hFFFFFFF8, 3'd2, 64'hFFFFFFFFFFFFFFF8};
        vecs[6]  = '{"jal",    32'h001000EF, 64'h2000, 3'd5, 32'h800,      3'd5, 64'h800};
        vecs[7]  = '{"auipc",  32'h12345117, 64'h10,   3'd4, 32'h12345000, 3'd4, 64'h12345000};
        vecs[8]  = '{"rtype",  32'h00000033, 64'h500,  3'd0, 32'h0,        3'd0, 64'h0};
        vecs[9]  = '{"csrrw",  32'h34011073, 64'h540,  3'd0, 32'h0,        3'd0, 64'h0};
        vecs[10] = '{"jalr-1", 32'hFFF08067, 64'h600,  3'd1, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF};
        vecs[11] = '{"lw7ff",  32'h7FF12083, 64'h0,    3'd1, 32'h7FF,      3'd1, 64'h7FF};
        vecs[12] = '{"bne16",  32'h00209863, 64'h700,  3'd3, 32'h10,       3'd3, 64'h10};

        reset = 1'b1; flush = 1'b0; drv_valid = 1'b0; drv_inst = '0; drv_pc = '0; drv_ordy = 1'b1;
        repeat (3) tick();
        chk_zero_out("reset");
        chk("reset in_ready32", 64'(if32.in_ready), 64'd0);
        chk("reset in_ready64", 64'(if64.in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("post-reset in_ready32", 64'(if32.in_ready), 64'd1);
        chk("post-reset in_ready64", 64'(if64.in_ready), 64'd1);
        tick();

        // Table vectors, one per transfer, out_ready held high
        for (int i = 0; i < 13; i++) begin
            drv_valid = 1'b1; drv_inst = vecs[i].inst; drv_pc = vecs[i].pc;
            tick();
            drv_valid = 1'b0;
            t32 = vecs[i].pc[31:0] + vecs[i].imm32;
            chk({vecs[i].name, " valid32"},  64'(if32.out_valid),  64'd1);
            chk({vecs[i].name, " fmt32"},    64'(if32.out_fmt),    64'(vecs[i].fmt32));
            chk({vecs[i].name, " imm32"},    64'(if32.out_imm),    64'(vecs[i].imm32));
            chk({vecs[i].name, " pc32"},     64'(if32.out_pc),     64'(vecs[i].pc[31:0]));
            chk({vecs[i].name, " target32"}, 64'(if32.out_target), 64'(t32));
            chk({vecs[i].name, " valid64"},  64'(if64.out_valid),  64'd1);
            chk({vecs[i].name, " fmt64"},    64'(if64.out_fmt),    64'(vecs[i].fmt64));
            chk({vecs[i].name, " imm64"},    if64.out_imm,         vecs[i].imm64);
            chk({vecs[i].name, " pc64"},     if64.out_pc,          vecs[i].pc);
            chk({vecs[i].name, " target64"}, if64.out_target,      vecs[i].pc + vecs[i].imm64);
        end
        repeat (2) tick();

        // Stream of 4 entries with out_ready low for cycles 2..4
        idx = 0; rdy_c2 = 1'b0; rdy_c3 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drv_ordy  = !(c >= 2 && c <= 4);
            drv_valid = (idx < 4);
            drv_inst  = 32'h00000013 | (32'(idx) << 20);
            drv_pc    = 64'h1000 + 64'(idx * 4);
            @(negedge clock);
            acc = drv_valid && if32.in_ready;
            if (if32.out_valid && drv_ordy) got32.push_back(if32.out_pc);
            if (if64.out_valid && drv_ordy) got64.push_back(if64.out_pc);
            if (c == 2) rdy_c2 = if32.in_ready;
            if (c == 3) rdy_c3 = if32.in_ready;
            if (c == 3 || c == 4) begin
                chk("stall hold valid", 64'(if32.out_valid), 64'd1);
                chk("stall hold pc",    64'(if32.out_pc),    64'h1004);
                chk("stall hold imm",   64'(if32.out_imm),   64'd1);
            end
            tick();
            if (acc) idx++;
        end
        drv_valid = 1'b0; drv_ordy = 1'b1;
`ifdef IMMGEN_SKID_EN
        chk("skid in_ready at fill", 64'(rdy_c2), 64'd1);
        chk("skid in_ready after fill", 64'(rdy_c3), 64'd0);
`else
        chk("in_ready while stalled c2", 64'(rdy_c2), 64'd0);
        chk("in_ready while stalled c3", 64'(rdy_c3), 64'd0);
`endif
        chk("stream count32", 64'(got32.size()), 64'd4);
        chk("stream count64", 64'(got64.size()), 64'd4);
        for (int k = 0; k < got32.size() && k < 4; k++)
            chk("stream order32", 64'(got32[k]), 64'h1000 + 64'(k * 4));
        for (int k = 0; k < got64.size() && k < 4; k++)
            chk("stream order64", got64[k], 64'h1000 + 64'(k * 4));
        tick();

        // Flush together with an input while the output is stalled
        drv_valid = 1'b1; drv_inst = 32'h00500093; drv_pc = 64'h2000; drv_ordy = 1'b1;
        tick();
        drv_pc = 64'h2004; drv_ordy = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; drv_valid = 1'b0;
        chk("flush valid32", 64'(if32.out_valid), 64'd0);
        chk("flush valid64", 64'(if64.out_valid), 64'd0);
        chk("flush in_ready32", 64'(if32.in_ready), 64'd1);
        drv_ordy = 1'b1; seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (if32.out_valid || if64.out_valid) seen = 1'b1;
            tick();
        end
        chk("flushed entry reappeared", 64'(seen), 64'd0);

        // Reset while stalled with main (and skid, if built) occupied
        drv_valid = 1'b1; drv_inst = 32'hFFF08093; drv_pc = 64'h3000; drv_ordy = 1'b1;
        tick();
        drv_pc = 64'h3004; drv_ordy = 1'b0;
        tick();
        chk("pre-reset valid32", 64'(if32.out_valid), 64'd1);
        drv_valid = 1'b0; reset = 1'b1;
        #1;
        chk("in_ready during reset32", 64'(if32.in_ready), 64'd0);
        chk("in_ready during reset64", 64'(if64.in_ready), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk_zero_out("stall-reset");
        chk("after reset in_ready32", 64'(if32.in_ready), 64'd1);
        chk("after reset in_ready64", 64'(if64.in_ready), 64'd1);
        drv_ordy = 1'b1; seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (if32.out_valid || if64.out_valid) seen = 1'b1;
            tick();
        end
        chk("entry survived reset", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
